// File: rtl/audio_chan_buf.sv
// audio_chan_buf: CHANNELS independent sample FIFOs sharing one block RAM.
// Writes enqueue into the selected channel. Each channel has a pending
// fetch bit, and a round-robin arbiter grants one pending channel per
// clock. A granted sample appears on rd_data_o one clock after the grant,
// through the RAM's registered read port. Sticky flags report fetches
// from an empty queue and writes dropped on a full queue.
module audio_chan_buf #(
    parameter int CHANNELS   = 4,
    parameter int DEPTH_LOG2 = 6,
    parameter int DATA_W     = 16
) (
    input  logic                                   clk,
    input  logic                                   reset_i,
    input  logic                                   wr_en_i,
    input  logic [$clog2(CHANNELS)-1:0]            wr_chan_i,
    input  logic [DATA_W-1:0]                      wr_data_i,
    output logic [CHANNELS-1:0]                    full_o,
    input  logic [CHANNELS-1:0]                    rd_req_i,
    output logic                                   rd_valid_o,
    output logic [$clog2(CHANNELS)-1:0]            rd_chan_o,
    output logic [DATA_W-1:0]                      rd_data_o,
    input  logic [CHANNELS-1:0]                    flush_i,
    input  logic                                   clr_flags_i,
    output logic [CHANNELS-1:0]                    underflow_o,
    output logic [CHANNELS-1:0]                    overflow_o,
    output logic [CHANNELS*(DEPTH_LOG2+1)-1:0]     level_o
);
    localparam int CW    = $clog2(CHANNELS);
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int AW    = CW + DEPTH_LOG2;
    localparam int WORDS = CHANNELS << DEPTH_LOG2;

    logic [PW-1:0]       wr_ptr_q [CHANNELS];
    logic [PW-1:0]       wr_ptr_d [CHANNELS];
    logic [PW-1:0]       rd_ptr_q [CHANNELS];
    logic [PW-1:0]       rd_ptr_d [CHANNELS];
    logic [PW-1:0]       level    [CHANNELS];
    logic [CHANNELS-1:0] empty, full;
    logic [CHANNELS-1:0] pend_q, pend_d;
    logic [CHANNELS-1:0] unf_q, unf_d, ovf_q, ovf_d;
    logic [CHANNELS-1:0] unf_set, ovf_set;
    logic [CW-1:0]       rr_q, rr_d;
    logic                rd_valid_q, rd_valid_d;
    logic                rd_zero_q, rd_zero_d;
    logic [CW-1:0]       rd_chan_q, rd_chan_d;

    logic [CHANNELS-1:0] eligible, grant_oh;
    logic                grant_vld;
    logic [CW-1:0]       grant_chan, idx;
    logic                wr_accept, rd_accept;
    logic [AW-1:0]       wr_addr, rd_addr;

    logic [DATA_W-1:0]   mem [WORDS];
    logic [DATA_W-1:0]   mem_rd_q;

    // Occupancy and full/empty come straight from the registered pointers.
    // The extra pointer bit tells a full queue apart from an empty one.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_level
        assign level[gi]                  = wr_ptr_q[gi] - rd_ptr_q[gi];
        assign empty[gi]                  = (wr_ptr_q[gi] == rd_ptr_q[gi]);
        assign full[gi]                   = level[gi][DEPTH_LOG2];
        assign level_o[gi*PW +: PW]       = level[gi];
    end
    assign full_o      = full;
    assign underflow_o = unf_q;
    assign overflow_o  = ovf_q;
    assign rd_valid_o  = rd_valid_q;
    assign rd_chan_o   = rd_chan_q;
    // An underflow grant returns zero instead of whatever the RAM register holds.
    assign rd_data_o   = (rd_valid_q && !rd_zero_q) ? mem_rd_q : '0;

    // Round-robin arbiter: the first pending, non-flushed channel at or after rr_q wins.
    always_comb begin
        eligible   = pend_q & ~flush_i;
        grant_vld  = 1'b0;
        grant_chan = '0;
        idx        = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            idx = rr_q + CW'(i);
            if (!grant_vld && eligible[idx]) begin
                grant_vld  = 1'b1;
                grant_chan = idx;
            end
        end
        grant_oh = grant_vld ? (CHANNELS'(1) << grant_chan) : '0;
    end

    // Accept/drop decisions and RAM addresses. A flush cancels a write to the same channel.
    always_comb begin
        wr_accept = wr_en_i && !flush_i[wr_chan_i] && !full[wr_chan_i];
        rd_accept = grant_vld && !empty[grant_chan];
        wr_addr   = {wr_chan_i, wr_ptr_q[wr_chan_i][DEPTH_LOG2-1:0]};
        rd_addr   = {grant_chan, rd_ptr_q[grant_chan][DEPTH_LOG2-1:0]};
        unf_set   = (grant_vld && empty[grant_chan]) ? grant_oh : '0;
        ovf_set   = '0;
        if (wr_en_i && !flush_i[wr_chan_i] && full[wr_chan_i]) begin
            ovf_set = CHANNELS'(1) << wr_chan_i;
        end
    end

    // Next state for pointers, pending bits, flags, arbiter pointer and read strobe.
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            wr_ptr_d[c] = wr_ptr_q[c];
            rd_ptr_d[c] = rd_ptr_q[c];
            if (wr_accept && (wr_chan_i == CW'(c))) begin
                wr_ptr_d[c] = wr_ptr_q[c] + PW'(1);
            end
            if (rd_accept && (grant_chan == CW'(c))) begin
                rd_ptr_d[c] = rd_ptr_q[c] + PW'(1);
            end
            if (flush_i[c]) begin
                wr_ptr_d[c] = '0;
                rd_ptr_d[c] = '0;
            end
        end
        // A request arriving with its own grant re-arms the bit for another fetch.
        pend_d     = (rd_req_i | (pend_q & ~grant_oh)) & ~flush_i;
        // Set events win over a simultaneous clear.
        unf_d      = (clr_flags_i ? '0 : unf_q) | unf_set;
        ovf_d      = (clr_flags_i ? '0 : ovf_q) | ovf_set;
        rr_d       = grant_vld ? grant_chan + CW'(1) : rr_q;
        rd_valid_d = grant_vld;
        rd_chan_d  = grant_vld ? grant_chan : rd_chan_q;
        rd_zero_d  = grant_vld ? empty[grant_chan] : rd_zero_q;
    end

    // Control state register; reset also suppresses an in-flight read strobe.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
            end
            pend_q     <= '0;
            unf_q      <= '0;
            ovf_q      <= '0;
            rr_q       <= '0;
            rd_valid_q <= 1'b0;
            rd_chan_q  <= '0;
            rd_zero_q  <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
            end
            pend_q     <= pend_d;
            unf_q      <= unf_d;
            ovf_q      <= ovf_d;
            rr_q       <= rr_d;
            rd_valid_q <= rd_valid_d;
            rd_chan_q  <= rd_chan_d;
            rd_zero_q  <= rd_zero_d;
        end
    end

    // Shared sample RAM. It has one write port and one registered read port
    // and no reset. A read never targets the address written in the same cycle.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_addr] <= wr_data_i;
        end
        if (rd_accept) begin
            mem_rd_q <= mem[rd_addr];
        end
    end
endmodule

// File: tb/tb_audio_chan_buf.sv
// Testbench for audio_chan_buf. A queue-based reference model is compared
// against the DUT on every clock, and directed scenarios check hand-computed
// literal results.
module tb_audio_chan_buf;
    localparam int CH    = 4;
    localparam int DL    = 6;
    localparam int DW    = 16;
    localparam int CW    = 2;
    localparam int PW    = 7;
    localparam int DEPTH = 64;

    logic              clk = 1'b0;
    logic              reset_i = 1'b1;
    logic              wr_en_i = 1'b0;
    logic [CW-1:0]     wr_chan_i = '0;
    logic [DW-1:0]     wr_data_i = '0;
    logic [CH-1:0]     full_o;
    logic [CH-1:0]     rd_req_i = '0;
    logic              rd_valid_o;
    logic [CW-1:0]     rd_chan_o;
    logic [DW-1:0]     rd_data_o;
    logic [CH-1:0]     flush_i = '0;
    logic              clr_flags_i = 1'b0;
    logic [CH-1:0]     underflow_o;
    logic [CH-1:0]     overflow_o;
    logic [CH*PW-1:0]  level_o;

    audio_chan_buf #(.CHANNELS(CH), .DEPTH_LOG2(DL), .DATA_W(DW)) dut (
        .clk(clk), .reset_i(reset_i), .wr_en_i(wr_en_i), .wr_chan_i(wr_chan_i),
        .wr_data_i(wr_data_i), .full_o(full_o), .rd_req_i(rd_req_i),
        .rd_valid_o(rd_valid_o), .rd_chan_o(rd_chan_o), .rd_data_o(rd_data_o),
        .flush_i(flush_i), .clr_flags_i(clr_flags_i), .underflow_o(underflow_o),
        .overflow_o(overflow_o), .level_o(level_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one FIFO queue per channel, pending bits, the
    // round-robin start position and the sticky flags.
    logic [DW-1:0] mq [CH][$];
    bit            m_pend [CH];
    int            m_rr = 0;
    logic [CH-1:0] m_unf = '0;
    logic [CH-1:0] m_ovf = '0;
    bit            m_valid = 1'b0;
    int            m_chan = 0;
    logic [DW-1:0] m_data = '0;

    task automatic model_step();
        int            g;
        int            sz [CH];
        logic [CH-1:0] unf_set;
        logic [CH-1:0] ovf_set;
        if (reset_i) begin
            for (int c = 0; c < CH; c++) begin
                mq[c].delete();
                m_pend[c] = 1'b0;
            end
            m_rr = 0; m_unf = '0; m_ovf = '0;
            m_valid = 1'b0; m_chan = 0; m_data = '0;
        end else begin
            for (int c = 0; c < CH; c++) sz[c] = mq[c].size();
            unf_set = '0;
            ovf_set = '0;
            g = -1;
            for (int i = 0; i < CH; i++) begin
                int c;
                c = (m_rr + i) % CH;
                if (g < 0 && m_pend[c] && !flush_i[c]) g = c;
            end
            m_valid = (g >= 0);
            if (g >= 0) begin
                m_chan = g;
                if (sz[g] == 0) begin
                    m_data = '0;
                    unf_set[g] = 1'b1;
                end else begin
                    m_data = mq[g].pop_front();
                end
                m_rr = (g + 1) % CH;
            end
            if (wr_en_i && !flush_i[wr_chan_i]) begin
                if (sz[wr_chan_i] == DEPTH) ovf_set[wr_chan_i] = 1'b1;
                else mq[wr_chan_i].push_back(wr_data_i);
            end
            for (int c = 0; c < CH; c++) begin
                m_pend[c] = rd_req_i[c] || (m_pend[c] && g != c);
                if (flush_i[c]) begin
                    m_pend[c] = 1'b0;
                    mq[c].delete();
                end
            end
            m_unf = (clr_flags_i ? '0 : m_unf) | unf_set;
            m_ovf = (clr_flags_i ? '0 : m_ovf) | ovf_set;
        end
    endtask

    task automatic compare();
        check("cmp_rd_valid", rd_valid_o, m_valid);
        if (m_valid) begin
            check("cmp_rd_chan", rd_chan_o, m_chan);
            check("cmp_rd_data", rd_data_o, m_data);
        end
        for (int c = 0; c < CH; c++) begin
            check($sformatf("cmp_level[%0d]", c), level_o[c*PW +: PW], mq[c].size());
            check($sformatf("cmp_full[%0d]", c), full_o[c], mq[c].size() == DEPTH);
        end
        check("cmp_underflow", underflow_o, m_unf);
        check("cmp_overflow", overflow_o, m_ovf);
    endtask

    // Update the model at each active edge, then compare once the DUT has settled.
    always @(posedge clk) begin
        model_step();
        #1;
        compare();
    end

    task automatic wr(input int ch, input logic [DW-1:0] d);
        wr_en_i = 1'b1; wr_chan_i = CW'(ch); wr_data_i = d;
        @(negedge clk);
        wr_en_i = 1'b0;
    endtask

    task automatic req(input logic [CH-1:0] mask);
        rd_req_i = mask;
        @(negedge clk);
        rd_req_i = '0;
    endtask

    task automatic clr_flags();
        clr_flags_i = 1'b1;
        @(negedge clk);
        clr_flags_i = 1'b0;
    endtask

    task automatic wait_valid(input string name, output logic [CW-1:0] ch, output logic [DW-1:0] d);
        int k;
        k = 0; ch = '0; d = '0;
        while (!rd_valid_o && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({name, "_strobe"}, rd_valid_o, 1'b1);
        if (rd_valid_o) begin
            ch = rd_chan_o;
            d  = rd_data_o;
            @(negedge clk);
        end
    endtask

    function automatic logic [PW-1:0] lvl(input int c);
        return level_o[c*PW +: PW];
    endfunction

    initial begin
        logic [CW-1:0] ch;
        logic [DW-1:0] d;
        logic [CW-1:0] exp_order [3];
        exp_order[0] = 2'd2; exp_order[1] = 2'd3; exp_order[2] = 2'd0;

        // Reset state
        #1;
        check("reset_rd_valid", rd_valid_o, 1'b0);
        check("reset_level", level_o, 0);
        check("reset_full", full_o, 0);
        check("reset_flags", {underflow_o, overflow_o}, 0);
        @(negedge clk); @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);

        // Simultaneous request on all channels: strictly round-robin from 0
        for (int c = 0; c < CH; c++) wr(c, DW'(16'h00A0 + c));
        req(4'b1111);
        for (int k = 0; k < CH; k++) begin
            wait_valid("rr4", ch, d);
            check($sformatf("rr4_chan%0d", k), ch, k);
            check($sformatf("rr4_data%0d", k), d, 16'h00A0 + k);
        end
        // Serve ch1 alone (rr -> 2), then request 0,2,3 together: order 2,3,0
        for (int c = 0; c < CH; c++) wr(c, DW'(16'h00B0 + c));
        req(4'b0010);
        wait_valid("rr_single", ch, d);
        check("rr_single_data", d, 16'h00B1);
        req(4'b1101);
        for (int k = 0; k < 3; k++) begin
            wait_valid("rr3", ch, d);
            check($sformatf("rr3_chan%0d", k), ch, exp_order[k]);
            check($sformatf("rr3_data%0d", k), d, 16'h00B0 + exp_order[k]);
        end

        // Fetch from an empty channel
        req(4'b0100);
        wait_valid("unf", ch, d);
        check("unf_chan", ch, 2);
        check("unf_data", d, 0);
        check("unf_flag", underflow_o, 4'b0100);
        clr_flags();
        check("unf_cleared", underflow_o, 0);

        // Flush wins over a same-cycle write
        wr(3, 16'h00C1); wr(3, 16'h00C2); wr(3, 16'h00C3);
        check("flush_pre_level", lvl(3), 3);
        flush_i = 4'b1000; wr_en_i = 1'b1; wr_chan_i = 2'd3; wr_data_i = 16'h00C4;
        @(negedge clk);
        flush_i = '0; wr_en_i = 1'b0;
        check("flush_level", lvl(3), 0);
        check("flush_no_ovf", overflow_o[3], 1'b0);
        req(4'b1000);
        wait_valid("flush_fetch", ch, d);
        check("flush_fetch_data", d, 0);
        check("flush_fetch_unf", underflow_o[3], 1'b1);
        clr_flags();

        // Two samples in order from ch1
        wr(1, 16'h1111); wr(1, 16'h2222);
        req(4'b0010);
        wait_valid("ch1_a", ch, d);
        check("ch1_a_chan", ch, 1);
        check("ch1_a_data", d, 16'h1111);
        req(4'b0010);
        wait_valid("ch1_b", ch, d);
        check("ch1_b_data", d, 16'h2222);
        check("ch1_level", lvl(1), 0);

        // Fill ch0, overflow on the 65th word, drain and prove it was dropped
        for (int i = 0; i < DEPTH; i++) wr(0, DW'(16'h0100 + i));
        check("fill_full_pre", full_o[0], 1'b1);
        wr(0, 16'hDEAD);
        check("fill_full", full_o[0], 1'b1);
        check("fill_ovf", overflow_o[0], 1'b1);
        check("fill_level", lvl(0), 64);
        for (int i = 0; i < DEPTH; i++) begin
            req(4'b0001);
            wait_valid("drain", ch, d);
            check($sformatf("drain_data%0d", i), d, 16'h0100 + i);
        end
        req(4'b0001);
        wait_valid("drain_extra", ch, d);
        check("drain_extra_data", d, 0);
        check("drain_extra_unf", underflow_o[0], 1'b1);

        // Reset while a fetch is pending
        wr(1, 16'h5555);
        req(4'b0010);
        reset_i = 1'b1;
        #1;
        check("rst_rd_valid", rd_valid_o, 1'b0);
        check("rst_rd_chan", rd_chan_o, 0);
        check("rst_rd_data", rd_data_o, 0);
        check("rst_level", level_o, 0);
        check("rst_full", full_o, 0);
        check("rst_flags", {underflow_o, overflow_o}, 0);
        @(negedge clk); @(negedge clk);
        reset_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rst_no_strobe", rd_valid_o, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/audio_chan_buf.md
AUDIO_CHAN_BUF -- requirements
Module: audio_chan_buf

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent sample queues (power of 2, 2..8).
REQ-002 SHALL have parameter DEPTH_LOG2, default 6, log2 of words per channel queue.
REQ-003 SHALL have parameter DATA_W, default 16, sample word width.
REQ-004 SHALL have port clk  in  1  single clock for all logic and the shared BRAM.
REQ-005 SHALL have port reset_i  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port wr_en_i  in  1  write one sample this cycle.
REQ-007 SHALL have port wr_chan_i  in  log2(CHANNELS)  target channel of write.
REQ-008 SHALL have port wr_data_i  in  DATA_W  sample to enqueue.
REQ-009 SHALL have port full_o  out  CHANNELS  per-channel queue full.
REQ-010 SHALL have port rd_req_i  in  CHANNELS  per-channel one-sample fetch request, level-sampled each clock.
REQ-011 SHALL have port rd_valid_o  out  1  one-cycle strobe, rd_data_o/rd_chan_o valid.
REQ-012 SHALL have port rd_chan_o  out  log2(CHANNELS)  channel of returned sample.
REQ-013 SHALL have port rd_data_o  out  DATA_W  returned sample.
REQ-014 SHALL have port flush_i  in  CHANNELS  per-channel queue flush.
REQ-015 SHALL have port clr_flags_i  in  1  clear all sticky flags.
REQ-016 SHALL have port underflow_o  out  CHANNELS  sticky: fetch served from empty queue.
REQ-017 SHALL have port overflow_o  out  CHANNELS  sticky: write dropped on full queue.
REQ-018 SHALL have port level_o  out  CHANNELS*(DEPTH_LOG2+1)  flattened per-channel occupancy, channel 0 in LSBs.

Function
REQ-019 SHALL store all queues in one inferred BRAM of CHANNELS*2^DEPTH_LOG2 words, address {chan, ptr[DEPTH_LOG2-1:0]}, one write and one registered read per clock.
REQ-020 SHALL keep per-channel wr_ptr and rd_ptr of DEPTH_LOG2+1 bits, wrapping modulo 2^(DEPTH_LOG2+1); level = wr_ptr - rd_ptr; empty when equal; full when level = 2^DEPTH_LOG2.
REQ-021 SHALL on wr_en_i with channel not full write BRAM at {wr_chan_i, wr_ptr} and increment that wr_ptr; with channel full drop the write and set overflow_o[wr_chan_i].
REQ-022 SHALL hold a pending bit per channel: set when rd_req_i[c] sampled high, cleared on grant; request and grant in the same cycle leave the bit set; a request on an already-pending channel is merged.
REQ-023 SHALL grant at most one pending channel per clock, round-robin: search starts at rr_ptr, after grant of channel c rr_ptr = (c+1) mod CHANNELS; rr_ptr resets to 0.
REQ-024 SHALL on grant of a non-empty channel read BRAM at {c, rd_ptr} and increment rd_ptr; rd_valid_o, rd_chan_o=c, rd_data_o=sample on the next clock.
REQ-025 SHALL on grant of an empty channel return rd_data_o = 0 with rd_valid_o, rd_chan_o=c, and set underflow_o[c]; rd_ptr unchanged.
REQ-026 SHALL, uncontended, assert rd_valid_o exactly one clock after the pending bit is set (two edges after rd_req_i first sampled).
REQ-027 SHALL evaluate empty/full from registered pointers: a same-cycle write to an empty channel being granted yields underflow; same-cycle write and read on one channel leave level unchanged.
REQ-028 SHALL never read a BRAM address written in the same cycle (guaranteed by REQ-020/021/027); no read-during-write bypass is required.
REQ-029 SHALL on flush_i[c] set wr_ptr and rd_ptr of c to 0 and clear pending[c]; flush takes priority over same-cycle write (dropped, no overflow) and grant of c (not granted).
REQ-030 SHALL clear all sticky flags on clr_flags_i; a same-cycle set event wins over clear.
REQ-031 SHALL drive level_o and full_o combinationally from registered pointers.

Reset
REQ-032 SHALL on reset_i asynchronously zero all pointers, pending bits, rr_ptr, flags, rd_valid_o, rd_chan_o, rd_data_o; full_o=0, level_o=0.
REQ-033 SHALL not clear BRAM contents on reset; reset mid-fetch SHALL suppress the in-flight rd_valid_o.

Verification
REQ-034 Write 0x1111,0x2222 to ch1, pulse rd_req_i[1] twice -> rd_valid_o with rd_chan_o=1, data 0x1111 then 0x2222; level_o ch1 ends 0.
REQ-035 Fill ch0 with 64 words (defaults), write a 65th -> full_o[0]=1, overflow_o[0]=1, level 64, 65th word never returned.
REQ-036 Request all 4 channels in one cycle, each holding one word -> four consecutive rd_valid_o strobes, chan order 0,1,2,3; next simultaneous request starts at rr_ptr.
REQ-037 Request ch2 while empty -> rd_valid_o, rd_chan_o=2, rd_data_o=0, underflow_o[2]=1; clr_flags_i -> underflow_o=0.
REQ-038 Write 3 words to ch3, assert flush_i[3] with simultaneous write to ch3 -> level ch3=0, overflow_o[3]=0, subsequent fetch underflows.
REQ-039 Assert reset_i mid-stream with fetch pending -> all outputs 0 same cycle, no rd_valid_o after release until new request.
